// File: rtl/ip_pkg.sv
// Shared IPv4 header constants, FSM state encoding and header layout for the UDP/IP TX path.
package ip_pkg;

    localparam logic [7:0] IP_VER_IHL   = 8'h45;
    localparam logic [7:0] IP_TOS       = 8'h00;
    localparam int         IP_HDR_BYTES = 20;
    localparam int         IP_HDR_WORDS = IP_HDR_BYTES / 2;
    localparam logic [7:0] IP_PROTO_UDP = 8'h11;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FOLD,
        TX,
        DONE
    } ip_state_t;

    // Declared in wire order so the packed vector is the header in network byte order.
    typedef struct packed {
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] id;
        logic [15:0] flag_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] checksum;
        logic [31:0] src;
        logic [31:0] dst;
    } ip_hdr_t;

    function automatic int hdr_beats(input int data_w);
        return IP_HDR_BYTES / (data_w / 8);
    endfunction

endpackage

// File: rtl/ip_checksum_acc.sv
// One's-complement 16-bit checksum accumulator: clear, add one word per cycle, fold+invert.
// Latency: checksum valid the cycle after fold; no backpressure (caller sequences add/fold).
// Backpressure: none; controls are single-cycle strobes from the owning FSM.
module ip_checksum_acc (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        add,
    input  logic        fold,
    input  logic [15:0] word,
    output logic [15:0] checksum
);

    logic [19:0] acc;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Two carry folds are enough for a 20-bit sum: the second add can carry at most once.
    always_comb begin
        fold1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
        fold2 = fold1[15:0] + {15'b0, fold1[16]};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc      <= '0;
            checksum <= '0;
        end else if (clear) begin
            acc      <= '0;
            checksum <= '0;
        end else begin
            if (add) begin
                acc <= acc + {4'b0, word};
            end
            if (fold) begin
                checksum <= ~fold2;
            end
        end
    end

endmodule

// File: rtl/ip_header_gen.sv
// IPv4 header generator: 20-byte header as DATA_W beats, MSB-first; IP_HDR_CHECKSUM_EN adds checksum calc.
// Latency: first beat 12 cycles after start with checksum, 1 without; done pulse 1 cycle after last beat.
// Backpressure: valid/ready; beat index and data_out hold while data_ready is low.
module ip_header_gen
    import ip_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter logic [7:0]  TTL         = 8'hFF,
    parameter logic [7:0]  PROTOCOL    = IP_PROTO_UDP,
    parameter logic [15:0] FLAG_OFFSET = 16'h0000,
    parameter logic [15:0] ID_INIT     = 16'h0000
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [31:0]       ip_s_addr,
    input  logic [31:0]       ip_d_addr,
    input  logic [15:0]       payload_len,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              data_last,
    output logic              busy,
    output logic              ip_header_tx_done
);

    localparam int         BEATS     = hdr_beats(DATA_W);
    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);
    localparam logic [4:0] LAST_WORD = 5'(IP_HDR_WORDS - 1);

    ip_state_t   state, state_nxt;
    logic [31:0] src_q, dst_q;
    logic [15:0] len_q;
    logic [15:0] id_q;
    logic [4:0]  cnt;
    logic [15:0] csum;
    ip_hdr_t     hdr;
    logic        accept;

    assign accept = (state == IDLE) && start;

    always_comb begin
        hdr.ver_ihl     = IP_VER_IHL;
        hdr.tos         = IP_TOS;
        hdr.total_len   = 16'(IP_HDR_BYTES) + len_q;
        hdr.id          = id_q;
        hdr.flag_offset = FLAG_OFFSET;
        hdr.ttl         = TTL;
        hdr.protocol    = PROTOCOL;
        hdr.checksum    = csum;
        hdr.src         = src_q;
        hdr.dst         = dst_q;
    end

`ifdef IP_HDR_CHECKSUM_EN
    logic [15:0] acc_word;

    // The accumulator is cleared on start, so the checksum field reads as zero while summing.
    assign acc_word = 16'(hdr >> (16 * (IP_HDR_WORDS - 1 - int'(cnt))));

    ip_checksum_acc u_csum (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .clear    (accept),
        .add      (state == CALC),
        .fold     (state == FOLD),
        .word     (acc_word),
        .checksum (csum)
    );
`else
    assign csum = 16'h0000;
`endif

    always_comb begin
        state_nxt         = state;
        data_valid        = 1'b0;
        data_last         = 1'b0;
        data_out          = '0;
        busy              = (state != IDLE);
        ip_header_tx_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef IP_HDR_CHECKSUM_EN
                    state_nxt = CALC;
`else
                    state_nxt = TX;
`endif
                end
            end
            CALC: begin
                if (cnt == LAST_WORD) begin
                    state_nxt = FOLD;
                end
            end
            FOLD: state_nxt = TX;
            TX: begin
                data_valid = 1'b1;
                data_last  = (cnt == LAST_BEAT);
                data_out   = DATA_W'(hdr >> (DATA_W * (BEATS - 1 - int'(cnt))));
                if (data_ready && data_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ip_header_tx_done = 1'b1;
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            cnt   <= '0;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            id_q  <= ID_INIT;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= ip_s_addr;
                        dst_q <= ip_d_addr;
                        len_q <= payload_len;
                        cnt   <= '0;
                    end
                end
                CALC: cnt <= (cnt == LAST_WORD) ? 5'd0 : cnt + 5'd1;
                TX: begin
                    if (data_valid && data_ready) begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    cnt  <= '0;
                    id_q <= id_q + 16'd1;
                end
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_header_gen.sv
// Directed bench for ip_header_gen: byte- and word-wide instances, backpressure, ID wrap, mid-packet reset.
module tb_ip_header_gen;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] ip_s_addr;
    logic [31:0] ip_d_addr;
    logic [15:0] payload_len;

    logic        start8, ready8, valid8, last8, busy8, done8;
    logic [7:0]  dout8;
    logic        start32, ready32, valid32, last32, busy32, done32;
    logic [31:0] dout32;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

`ifdef IP_HDR_CHECKSUM_EN
    localparam int          LAT    = 12;
    localparam logic [15:0] CS_ID0 = 16'hB861;
    localparam logic [15:0] CS_ID1 = 16'hB860;
    localparam logic [15:0] CS_IDF = 16'hB861;
`else
    localparam int          LAT    = 1;
    localparam logic [15:0] CS_ID0 = 16'h0000;
    localparam logic [15:0] CS_ID1 = 16'h0000;
    localparam logic [15:0] CS_IDF = 16'h0000;
`endif

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    ip_header_gen #(
        .DATA_W(8), .TTL(8'h40), .PROTOCOL(8'h11), .FLAG_OFFSET(16'h4000), .ID_INIT(16'h0000)
    ) dut8 (
        .aclk(aclk), .aresetn(aresetn), .start(start8), .ip_s_addr(ip_s_addr),
        .ip_d_addr(ip_d_addr), .payload_len(payload_len), .data_ready(ready8),
        .data_out(dout8), .data_valid(valid8), .data_last(last8), .busy(busy8),
        .ip_header_tx_done(done8)
    );

    ip_header_gen #(
        .DATA_W(32), .TTL(8'h40), .PROTOCOL(8'h11), .FLAG_OFFSET(16'h4000), .ID_INIT(16'hFFFF)
    ) dut32 (
        .aclk(aclk), .aresetn(aresetn), .start(start32), .ip_s_addr(ip_s_addr),
        .ip_d_addr(ip_d_addr), .payload_len(payload_len), .data_ready(ready32),
        .data_out(dout32), .data_valid(valid32), .data_last(last32), .busy(busy32),
        .ip_header_tx_done(done32)
    );

    function automatic logic [159:0] exp_hdr(input logic [15:0] id, input logic [15:0] cs);
        return {8'h45, 8'h00, 16'h0073, id, 16'h4000, 8'h40, 8'h11, cs, 32'hC0A80001, 32'hC0A800C7};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_valid8(output int n);
        n = 0;
        while (!valid8 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic rx8(input logic [15:0] id, input logic [15:0] cs, input int stall_beat, input int t0);
        logic [159:0] e;
        int n;
        e = exp_hdr(id, cs);
        wait_valid8(n);
        chk("lat8", n + 1, LAT);
        for (int b = 0; b < 20; b++) begin
            if (b == stall_beat) begin
                ready8 = 1'b0;
                repeat (3) begin
                    tick();
                    chk("hold8", dout8, 8'(e >> (8 * (19 - b))));
                    chk("hold_vld8", valid8, 1);
                end
                ready8 = 1'b1;
            end
            chk("byte8", dout8, 8'(e >> (8 * (19 - b))));
            chk("last8", last8, (b == 19));
            tick();
        end
        chk("done8", done8, 1);
        chk("done_lat8", cyc - t0, LAT + 19 + ((stall_beat >= 0) ? 3 : 0));
        tick();
        chk("done8_off", done8, 0);
        chk("busy8_off", busy8, 0);
    endtask

    task automatic rx32(input logic [15:0] id, input logic [15:0] cs, input logic poke, input int t0);
        logic [159:0] e;
        int n;
        e = exp_hdr(id, cs);
        n = 0;
        while (!valid32 && n < 40) begin
            tick();
            n++;
        end
        chk("lat32", n + 1, LAT);
        for (int b = 0; b < 5; b++) begin
            chk("word32", dout32, 32'(e >> (32 * (4 - b))));
            chk("last32", last32, (b == 4));
            if (poke && b == 2) start32 = 1'b1;
            tick();
            start32 = 1'b0;
        end
        chk("done32", done32, 1);
        chk("done_lat32", cyc - t0, LAT + 4);
        // A start landing in the done cycle must be dropped.
        if (poke) start32 = 1'b1;
        tick();
        start32 = 1'b0;
        chk("done32_off", done32, 0);
        chk("busy32_off", busy32, 0);
    endtask

    initial begin
        int n;
        int t0;
        ip_s_addr   = 32'hC0A80001;
        ip_d_addr   = 32'hC0A800C7;
        payload_len = 16'd95;
        start8 = 1'b0; ready8 = 1'b1;
        start32 = 1'b0; ready32 = 1'b1;

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_dout8", dout8, 0);
        chk("rst_vld8", valid8, 0);
        chk("rst_last8", last8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_dout32", dout32, 0);
        chk("rst_vld32", valid32, 0);
        aresetn = 1'b1;
        tick();

        // Packet abandoned by reset while beat 7 is on the bus.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("busy8_start", busy8, 1);
        wait_valid8(n);
        chk("lat8_a", n + 1, LAT);
        repeat (7) tick();
        chk("beat7", dout8, 8'h00);
        chk("beat7_vld", valid8, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_vld8", valid8, 0);
        chk("arst_busy8", busy8, 0);
        chk("arst_dout8", dout8, 0);
        chk("arst_last8", last8, 0);
        tick();
        aresetn = 1'b1;
        repeat (3) begin
            tick();
            chk("arst_nodone8", done8, 0);
        end

        // Same ID reused after reset; full checksum vector.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        t0 = cyc;
        rx8(16'h0000, CS_ID0, -1, t0);

        // Next ID with a 3-cycle stall on the fourth beat.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        t0 = cyc;
        rx8(16'h0001, CS_ID1, 3, t0);

        // Word-wide instance: ID 0xFFFF then wrap to 0x0000, with stray starts.
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        t0 = cyc;
        rx32(16'hFFFF, CS_IDF, 1'b1, t0);

        start32 = 1'b1;
        tick();
        start32 = 1'b0;
        t0 = cyc;
        rx32(16'h0000, CS_ID0, 1'b0, t0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ip_header_gen.md
# ip_header_gen

Parametrised IPv4 header generator; successor to the fixed 8-bit header transmitter in the UDP/IP TX path. It sits after the Ethernet header stage and starts on that stage's done pulse. It emits the 20-byte IPv4 header in network byte order over a configurable-width stream with valid/ready backpressure. It also computes the real header checksum, derives Total Length from the payload length, and increments Identification once per packet.

## Interface
- `DATA_W`, 8: output beat width in bits; legal values 8, 16, 32. Beats per header = 20/(DATA_W/8).
- `TTL`, 8'hFF: Time To Live field.
- `PROTOCOL`, 8'h11: protocol field (UDP).
- `FLAG_OFFSET`, 16'h0000: flags/fragment-offset field.
- `ID_INIT`, 16'h0000: Identification value after reset.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; one clock, asynchronous active-low.
- `start`  in  1  one-cycle pulse from Ethernet header stage.
- `ip_s_addr`  in  32  source address; sampled on accepted `start`.
- `ip_d_addr`  in  32  destination address; sampled on accepted `start`.
- `payload_len`  in  16  L4 byte count; sampled on accepted `start`.
- `data_ready`  in  1  downstream accepts beat.
- `data_out`  out  DATA_W  header beat; earliest byte in MSBs.
- `data_valid`  out  1  beat valid.
- `data_last`  out  1  final header beat.
- `busy`  out  1  high from accepted `start` until done.
- `ip_header_tx_done`  out  1  one-cycle pulse after last beat handshake.

## Operation
- States: `IDLE`, `CALC`, `FOLD`, `TX`, `DONE`.
- `IDLE`: `start`=1 latches addresses, payload_len, current ID; goes to `CALC`. `start` in any other state is ignored.
- Total Length = 20 + payload_len, truncated to 16 bits (wraps modulo 2^16, no error).
- `CALC`: 10 cycles. Adds one 16-bit header word per cycle into a 20-bit accumulator. Checksum field counts as 0x0000.
- `FOLD`: 1 cycle. Fold carries twice (sum[15:0]+sum[19:16]), invert, store as checksum.
- `TX`: presents beat k. Beat index advances only on `data_valid && data_ready`. `data_out` is held stable while stalled. `data_last` is high on beat 20/(DATA_W/8)-1.
- Last handshake goes to `DONE`. `DONE`: pulses `ip_header_tx_done`, increments ID (0xFFFF wraps to 0x0000), returns to `IDLE`.
- Field order: 0x45, 0x00, TotalLen, ID, FLAG_OFFSET, TTL, PROTOCOL, checksum, src, dst. All fields big-endian.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `data_last`=0, `busy`=0, `ip_header_tx_done`=0. ID=ID_INIT, state `IDLE`.
- `start` sampled at edge N. `busy` is high from N. First `data_valid` is at edge N+12 with checksum enabled, N+1 without.
- With `data_ready` held high: one beat per cycle. The done pulse comes one cycle after the last handshake. The next `start` is accepted the cycle after the pulse.
- `aresetn` low mid-packet: immediate return to reset values. A partial header is abandoned, with no done pulse and no ID increment.
- `start` coincident with the done cycle is ignored.

## Configuration
- `IP_HDR_CHECKSUM_EN` defined: `CALC`/`FOLD` are present and the checksum field is computed.
- Not defined: `CALC`/`FOLD` and the accumulator are removed. `IDLE` goes straight to `TX` and the checksum field is 0x0000 (offload to MAC).

## Structure
- Package `ip_pkg`: `IP_VER_IHL` (8'h45), `IP_TOS` (8'h00), `IP_HDR_BYTES` (20), `IP_PROTO_UDP` (8'h11), state enum typedef.
- Sub-module `ip_checksum_acc`: sequential one's-complement accumulator with clear/add/fold controls. Reused later by the UDP stage.

## Test plan
- Checksum case: DATA_W=8, TTL=8'h40, FLAG_OFFSET=16'h4000, ID_INIT=0, src C0A80001, dst C0A800C7, payload_len 95 -> bytes 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7, `data_last` on the 20th beat, done one cycle later.
- DATA_W=32, same inputs -> 5 beats: 45000073, 00004000, 4011B861, C0A80001, C0A800C7.
- Backpressure: deassert `data_ready` for 3 cycles on beat 4 -> `data_out` is held, no byte is skipped or repeated, and done is delayed 3 cycles.
- Back-to-back packets from ID_INIT=16'hFFFF -> ID fields FFFF then 0000. A `start` pulsed while `busy` is ignored.
- Reset mid-TX at beat 7 -> outputs go to 0 asynchronously, no done pulse. The next packet reuses the same ID.
- Build without `IP_HDR_CHECKSUM_EN` -> first valid at N+1 and bytes 11-12 are 00 00.
